// File: rtl/mult32x32_fsm_pkg.sv
// Shared types and constants for the word-serial 32x32 multiplier.
// Holds the sequencer state enum, default word counts and a width helper.
package mult_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int MULT_A_WORDS = 2;
    localparam int MULT_B_WORDS = 2;

    // $clog2 with a floor of one bit, so single-word operands still get a port.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mult32x32_fsm.sv
// Sequencer for the word-serial multiplier datapath (mult32x32_arith).
// Ports: clk, reset (async, active-high), start in; busy, done, clr_prod,
//        upd_prod, a_sel, b_sel, shift_sel (= a_sel + b_sel) out.
module mult32x32_fsm
    import mult_pkg::*;
#(
    parameter int A_WORDS = MULT_A_WORDS,
    parameter int B_WORDS = MULT_B_WORDS,
    localparam int AW = clog2_min1(A_WORDS),
    localparam int BW = clog2_min1(B_WORDS),
    localparam int SW = clog2_min1(A_WORDS + B_WORDS - 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          clr_prod,
    output logic          upd_prod,
    output logic [AW-1:0] a_sel,
    output logic [BW-1:0] b_sel,
    output logic [SW-1:0] shift_sel
);

    localparam logic [AW-1:0] A_LAST = AW'(A_WORDS - 1);
    localparam logic [BW-1:0] B_LAST = BW'(B_WORDS - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] a_idx_q, a_idx_d;
    logic [BW-1:0] b_idx_q, b_idx_d;
    logic          done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_idx_q <= '0;
            b_idx_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_idx_q <= a_idx_d;
            b_idx_q <= b_idx_d;
            done_q  <= done_d;
        end
    end

    // B index is the inner loop; A advances when B wraps.
    always_comb begin
        state_d = state_q;
        a_idx_d = a_idx_q;
        b_idx_d = b_idx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_idx_d = '0;
                    b_idx_d = '0;
                end
            end
            RUN: begin
                if (b_idx_q == B_LAST) begin
                    b_idx_d = '0;
                    if (a_idx_q == A_LAST) begin
                        state_d = IDLE;
                        a_idx_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        a_idx_d = a_idx_q + AW'(1);
                    end
                end else begin
                    b_idx_d = b_idx_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // clr_prod is Mealy on start so the product clears on the accepting edge;
    // it is gated by reset because start may be high while reset is held.
    always_comb begin
        busy      = 1'b0;
        upd_prod  = 1'b0;
        clr_prod  = 1'b0;
        a_sel     = '0;
        b_sel     = '0;
        shift_sel = '0;
        done      = done_q;
        case (state_q)
            IDLE: begin
                clr_prod = start & ~reset;
            end
            RUN: begin
                busy      = 1'b1;
                upd_prod  = 1'b1;
                a_sel     = a_idx_q;
                b_sel     = b_idx_q;
                shift_sel = SW'(a_idx_q) + SW'(b_idx_q);
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mult32x32_fsm.sv
// Testbench for mult32x32_fsm: default 2x2 instance plus a 4x2 instance.
// A behavioural datapath model accumulates word products and is compared to a*b.
module tb_mult32x32_fsm;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic sel2;

    logic       start1, busy1, done1, clr1, upd1;
    logic [0:0] a_sel1, b_sel1;
    logic [1:0] sh1;

    logic       start2, busy2, done2, clr2, upd2;
    logic [1:0] a_sel2;
    logic [0:0] b_sel2;
    logic [2:0] sh2;

    assign start1 = sel2 ? 1'b0 : start;
    assign start2 = sel2 ? start : 1'b0;

    always #5 clk = ~clk;

    mult32x32_fsm dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .busy(busy1), .done(done1), .clr_prod(clr1), .upd_prod(upd1),
        .a_sel(a_sel1), .b_sel(b_sel1), .shift_sel(sh1)
    );

    mult32x32_fsm #(.A_WORDS(4), .B_WORDS(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .busy(busy2), .done(done2), .clr_prod(clr2), .upd_prod(upd2),
        .a_sel(a_sel2), .b_sel(b_sel2), .shift_sel(sh2)
    );

    logic m_busy, m_done, m_clr, m_upd;
    int   m_a, m_b, m_sh;

    always_comb begin
        m_busy = sel2 ? busy2 : busy1;
        m_done = sel2 ? done2 : done1;
        m_clr  = sel2 ? clr2  : clr1;
        m_upd  = sel2 ? upd2  : upd1;
        m_a    = sel2 ? int'(a_sel2) : int'(a_sel1);
        m_b    = sel2 ? int'(b_sel2) : int'(b_sel1);
        m_sh   = sel2 ? int'(sh2)    : int'(sh1);
    end

    int checks = 0;
    int failures = 0;

    logic [127:0] op_a, op_b;
    logic [255:0] prod;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model the datapath for the cycle ending now, then advance one clock.
    task automatic step(input logic s);
        logic [255:0] pp;
        if (m_clr) begin
            prod = '0;
        end else if (m_upd) begin
            pp = 256'(op_a[32*m_a +: 32]) * 256'(op_b[32*m_b +: 32]);
            prod = prod + (pp << (32 * m_sh));
        end
        @(posedge clk);
        #1;
        start = s;
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 256'(m_busy), 256'(0));
        chk({tag, "_upd"},  256'(m_upd),  256'(0));
        chk({tag, "_asel"}, 256'(m_a),    256'(0));
        chk({tag, "_bsel"}, 256'(m_b),    256'(0));
        chk({tag, "_sh"},   256'(m_sh),   256'(0));
    endtask

    // accepted: the current cycle already shows start=1 in IDLE.
    task automatic run_op(input string tag, input int na, input int nb,
                          input bit poke, input bit keep, input bit accepted);
        int k = 0;
        if (!accepted) begin
            step(1'b1);
        end
        chk({tag, "_acc_clr"},  256'(m_clr),  256'(1));
        chk({tag, "_acc_busy"}, 256'(m_busy), 256'(0));
        for (int ia = 0; ia < na; ia++) begin
            for (int ib = 0; ib < nb; ib++) begin
                step((keep || (poke && k == 2)) ? 1'b1 : 1'b0);
                chk({tag, "_run_busy"}, 256'(m_busy), 256'(1));
                chk({tag, "_run_upd"},  256'(m_upd),  256'(1));
                chk({tag, "_run_clr"},  256'(m_clr),  256'(0));
                chk({tag, "_run_done"}, 256'(m_done), 256'(0));
                chk({tag, "_run_asel"}, 256'(m_a),    256'(ia));
                chk({tag, "_run_bsel"}, 256'(m_b),    256'(ib));
                chk({tag, "_run_sh"},   256'(m_sh),   256'(ia + ib));
                k++;
            end
        end
        step(keep);
        chk({tag, "_done"},      256'(m_done), 256'(1));
        chk({tag, "_done_busy"}, 256'(m_busy), 256'(0));
        chk({tag, "_done_clr"},  256'(m_clr),  256'(keep));
        chk({tag, "_prod"},      prod,  256'(op_a) * 256'(op_b));
        if (!keep) begin
            step(1'b0);
            chk({tag, "_done_clear"}, 256'(m_done), 256'(0));
            chk_idle({tag, "_after"});
        end
    endtask

    task automatic rand_ops(input int na, input int nb);
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < na; i++) op_a[32*i +: 32] = $urandom;
        for (int i = 0; i < nb; i++) op_b[32*i +: 32] = $urandom;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        sel2  = 1'b0;
        prod  = '0;
        op_a  = '0;
        op_b  = '0;

        repeat (2) step(1'b0);
        start = 1'b1;
        #1;
        chk("rst_clr_gated", 256'(m_clr), 256'(0));
        chk("rst_done", 256'(m_done), 256'(0));
        chk_idle("rst");
        start = 1'b0;

        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            chk("idle_clr", 256'(m_clr), 256'(0));
            chk("idle_done", 256'(m_done), 256'(0));
            chk_idle("idle");
        end

        op_a = 128'd3;
        op_b = 128'd3;
        run_op("basic", 2, 2, 1'b0, 1'b0, 1'b0);

        op_a = {96'd0, 32'hffff_ffff, 32'hffff_ffff} >> 0;
        op_b = {96'd0, 32'hffff_ffff, 32'hffff_ffff} >> 0;
        run_op("maxval", 2, 2, 1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 4; t++) begin
            rand_ops(2, 2);
            run_op("rand", 2, 2, 1'b0, 1'b0, 1'b0);
        end

        rand_ops(2, 2);
        run_op("poke", 2, 2, 1'b1, 1'b0, 1'b0);

        op_a = 128'h2_0000_0001;
        op_b = 128'h3_0000_0005;
        run_op("hold0", 2, 2, 1'b0, 1'b1, 1'b0);
        run_op("hold1", 2, 2, 1'b0, 1'b1, 1'b1);
        run_op("hold2", 2, 2, 1'b0, 1'b0, 1'b1);

        step(1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        chk("pre_rst_asel", 256'(m_a), 256'(1));
        reset = 1'b1;
        #1;
        chk("async_rst_clr", 256'(m_clr), 256'(0));
        chk("async_rst_done", 256'(m_done), 256'(0));
        chk_idle("async_rst");
        step(1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b1;
        #1;
        chk("rel_start_clr", 256'(m_clr), 256'(1));
        chk("rel_start_done", 256'(m_done), 256'(0));
        rand_ops(2, 2);
        prod = '0;
        run_op("after_rst", 2, 2, 1'b0, 1'b0, 1'b1);

        sel2 = 1'b1;
        #1;
        chk_idle("w42_idle");
        for (int t = 0; t < 3; t++) begin
            rand_ops(4, 2);
            run_op("w42", 4, 2, 1'b0, 1'b0, 1'b0);
        end
        sel2 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
